trigger_network_sync: RTL

- Network-level companion to the per-actor trigger FSMs; one instance per actor network.
- Fans a single network ap_start out to NUM_ACTORS triggers.
- Aggregates each trigger's sleep/sync_exec/sync_wait status into the broadcast all_sleep/all_sync/all_sync_wait inputs the triggers consume.
- Collects per-trigger ap_done into one network ap_done/ap_ready, and provides run-statistics counters for the host.

---
 rtl/trigger_network_sync.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/trigger_network_sync.sv
// -----------------------------------------------------------------------------
// trigger_network_sync
//
// Network-level companion to the per-actor trigger FSMs. A single network
// ap_start is fanned out to NUM_ACTORS triggers. The block aggregates their
// sleep/sync status into the broadcast all_sleep/all_sync/all_sync_wait
// signals. It folds the per-trigger ap_done pulses into one network
// ap_done/ap_ready pulse. It also keeps run statistics for the host.
//
// Handshake: ap_start is a level request. It is accepted only in IDLE and only
// when every participating trigger reports idle. It is not latched, so the
// host holds it until ap_idle falls. ap_done/ap_ready pulse for exactly one
// cycle when every participating trigger has reported done during the run.
//
// Parameters:
//   NUM_ACTORS  number of trigger instances served (1..64)
//   ACTOR_MASK  bit i = 1 means trigger i participates. Masked-off bits read
//               as idle/sleeping/synced/done.
//   CNT_W       width of the statistics counters
//
// Ports:
//   ap_clk, ap_rst             clock, synchronous active-high reset
//   ap_start                   network start request (level)
//   ap_done, ap_ready          one-cycle completion pulse (identical)
//   ap_idle                    high while in IDLE
//   trig_start                 one-cycle start pulse to each participating trigger
//   trig_idle/done/sleep       status inputs from each trigger
//   trig_sync_exec/sync_wait   sync status inputs from each trigger
//   all_sleep/all_sync/all_sync_wait  combinational broadcasts, 0 outside RUN
//   run_cycles                 RUN cycles of the last or current run (saturating)
//   sync_rounds                all_sync rising edges in the last or current run
//   dbg_state                  current FSM state (IDLE=0, START=1, RUN=2, DONE=3)
// -----------------------------------------------------------------------------
module trigger_network_sync #(
  parameter int                    NUM_ACTORS = 4,
  parameter logic [NUM_ACTORS-1:0] ACTOR_MASK = {NUM_ACTORS{1'b1}},
  parameter int                    CNT_W      = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic [NUM_ACTORS-1:0] trig_start,
  input  logic [NUM_ACTORS-1:0] trig_idle,
  input  logic [NUM_ACTORS-1:0] trig_done,
  input  logic [NUM_ACTORS-1:0] trig_sleep,
  input  logic [NUM_ACTORS-1:0] trig_sync_exec,
  input  logic [NUM_ACTORS-1:0] trig_sync_wait,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic [CNT_W-1:0]      run_cycles,
  output logic [CNT_W-1:0]      sync_rounds,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A network with no participants never performs a sync round. The
  // vacuously-true all_sync it shows for its single RUN cycle is not counted.
  localparam bit HAS_ACTORS = (ACTOR_MASK != {NUM_ACTORS{1'b0}});

  state_t                  state;
  logic [NUM_ACTORS-1:0]   done_seen;
  logic                    sync_prev;

  // Masked-off triggers read as idle / done / sleeping / synced.
  logic [NUM_ACTORS-1:0]   m_idle;
  logic [NUM_ACTORS-1:0]   m_done;
  logic [NUM_ACTORS-1:0]   m_sleep;
  logic [NUM_ACTORS-1:0]   m_sync;
  logic [NUM_ACTORS-1:0]   m_sync_wait;
  logic                    in_run;
  logic                    all_done;

  assign m_idle      = trig_idle  | ~ACTOR_MASK;
  assign m_done      = trig_done  | ~ACTOR_MASK;
  assign m_sleep     = trig_sleep | ~ACTOR_MASK;
  assign m_sync      = trig_sync_exec | trig_sync_wait | ~ACTOR_MASK;
  assign m_sync_wait = trig_sync_wait | ~ACTOR_MASK;

  assign in_run = (state == S_RUN);

  // Zero-latency broadcasts. The triggers react to them in the same cycle.
  assign all_sleep     = in_run & (&m_sleep);
  assign all_sync      = in_run & (&m_sync);
  assign all_sync_wait = all_sync & (&m_sync_wait);

  // Include this cycle's done pulses so that final pulses arriving together
  // complete the run without an extra cycle.
  assign all_done = &(done_seen | m_done);

  assign dbg_state = state;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= S_IDLE;
      trig_start  <= '0;
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      ap_idle     <= 1'b1;
      done_seen   <= '0;
      sync_prev   <= 1'b0;
      run_cycles  <= '0;
      sync_rounds <= '0;
    end else begin
      // all_sync is forced low outside RUN, so each run starts with a clean
      // edge detector.
      sync_prev  <= all_sync;
      trig_start <= '0;
      ap_done    <= 1'b0;
      ap_ready   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ap_start && (&m_idle)) begin
            state       <= S_START;
            trig_start  <= ACTOR_MASK;
            ap_idle     <= 1'b0;
            done_seen   <= '0;
            run_cycles  <= '0;
            sync_rounds <= '0;
          end
        end

        S_START: begin
          state <= S_RUN;
        end

        S_RUN: begin
          if (run_cycles != CNT_MAX) begin
            run_cycles <= run_cycles + CNT_ONE;
          end
          if (HAS_ACTORS && all_sync && !sync_prev && (sync_rounds != CNT_MAX)) begin
            sync_rounds <= sync_rounds + CNT_ONE;
          end
          done_seen <= done_seen | (trig_done & ACTOR_MASK);
          if (all_done) begin
            state    <= S_DONE;
            ap_done  <= 1'b1;
            ap_ready <= 1'b1;
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          ap_idle <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
